// File: rtl/serial_pad_pkg.sv
// Shared types and constants for the serial gamepad poller.
// Optional feature macro used by the top: PAD_PRESS_EDGE_EN (press-edge output).
package serial_pad_pkg;

  // Poll sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // NES controller bit positions, in shift-out order
  localparam int NES_A      = 0;
  localparam int NES_B      = 1;
  localparam int NES_SELECT = 2;
  localparam int NES_START  = 3;
  localparam int NES_UP     = 4;
  localparam int NES_DOWN   = 5;
  localparam int NES_LEFT   = 6;
  localparam int NES_RIGHT  = 7;

  // Default timing for a 40 MHz system clock
  localparam int DEF_POLL_DIV  = 666667;  // 60 Hz poll rate
  localparam int DEF_LATCH_CYC = 480;     // 12 us latch
  localparam int DEF_HALF_CYC  = 240;     // 6 us per pulse half-period
  localparam int DEF_NUM_BITS  = 8;
  localparam int DEF_NUM_PADS  = 1;

  // Width needed to hold values 0..n-1, never below one bit
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

  // Larger of two integers
  function automatic int max_int(input int a, input int b);
    int m;
    if (a > b) begin
      m = a;
    end else begin
      m = b;
    end
    return m;
  endfunction

endpackage

// File: rtl/pad_tick_divider.sv
// Poll period counter: counts 0..POLL_DIV-1 continuously and flags the
// cycle in which the counter is zero. Also exposes a one-cycle lookahead
// so the sequencer can enter its latch phase in step with poll_tick.
module pad_tick_divider
  import serial_pad_pkg::*;
#(
  parameter int POLL_DIV = DEF_POLL_DIV
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_poll_tick,
  output logic o_tick_next
);

  localparam int CW = clog2_min1(POLL_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(POLL_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;
  logic [CW-1:0] w_cnt_next;
  logic          w_wrap;

  // Next counter value with wrap at the end of the period
  always_comb begin
    w_wrap     = 1'b0;
    w_cnt_next = r_cnt;
    if (r_cnt == CNT_LAST) begin
      w_wrap     = 1'b1;
      w_cnt_next = '0;
    end else begin
      w_wrap     = 1'b0;
      w_cnt_next = r_cnt + CW'(1);
    end
  end

  // Counter and registered tick (high while the counter reads zero)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_tick <= w_wrap;
    end
  end

  assign o_poll_tick = r_tick;
  assign o_tick_next = w_wrap;

endmodule

// File: rtl/serial_pad_poller.sv
// Multi-pad NES/SNES serial gamepad poller. Generates shared latch/pulse
// waveforms, shifts each pad's active-low data line into a per-pad register
// and publishes an active-high snapshot with a one-cycle valid strobe.
// Optional: define PAD_PRESS_EDGE_EN to add the buttons_pressed output.
module serial_pad_poller
  import serial_pad_pkg::*;
#(
  parameter int POLL_DIV  = DEF_POLL_DIV,
  parameter int LATCH_CYC = DEF_LATCH_CYC,
  parameter int HALF_CYC  = DEF_HALF_CYC,
  parameter int NUM_BITS  = DEF_NUM_BITS,
  parameter int NUM_PADS  = DEF_NUM_PADS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUM_PADS-1:0]          pad_data,
  output logic                         latch,
  output logic                         pulse,
  output logic                         poll_tick,
  output logic [NUM_PADS*NUM_BITS-1:0] buttons,
  output logic                         buttons_valid,
  output logic                         busy
`ifdef PAD_PRESS_EDGE_EN
  ,
  output logic [NUM_PADS*NUM_BITS-1:0] buttons_pressed
`endif
);

  localparam int TOTAL  = NUM_PADS * NUM_BITS;
  localparam int IDX_W  = clog2_min1(NUM_BITS);
  localparam int PH_W   = clog2_min1(max_int(LATCH_CYC, HALF_CYC));
  localparam logic [PH_W-1:0]  LATCH_LAST = PH_W'(LATCH_CYC - 1);
  localparam logic [PH_W-1:0]  HALF_LAST  = PH_W'(HALF_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_BITS - 1);

  // Parameter sanity: these guarantee one poll ends before the next tick.
  if (POLL_DIV <= LATCH_CYC + 2 * HALF_CYC * NUM_BITS + 2) begin : g_bad_div
    $error("serial_pad_poller: POLL_DIV too small for one complete poll");
  end
  if (LATCH_CYC < 1 || HALF_CYC < 1) begin : g_bad_timing
    $error("serial_pad_poller: LATCH_CYC and HALF_CYC must be at least 1");
  end
  if (NUM_BITS < 1 || NUM_PADS < 1) begin : g_bad_size
    $error("serial_pad_poller: NUM_BITS and NUM_PADS must be at least 1");
  end

  state_e           r_state;
  state_e           w_state_next;
  logic [PH_W-1:0]  r_ph;
  logic [PH_W-1:0]  w_ph_next;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_next;
  logic             w_sample;
  logic [TOTAL-1:0] r_shift;
  logic [TOTAL-1:0] w_shift_next;
  logic [TOTAL-1:0] r_buttons;
  logic             r_latch;
  logic             r_pulse;
  logic             r_valid;
  logic             r_busy;
  logic             w_tick_next;

  pad_tick_divider #(
    .POLL_DIV (POLL_DIV)
  ) u_div (
    .i_clk       (clk),
    .i_rst_n     (reset),
    .o_poll_tick (poll_tick),
    .o_tick_next (w_tick_next)
  );

  // Sequencer next-state logic. The IDLE->LATCH move uses the divider's
  // lookahead so the latch phase starts in the same cycle poll_tick is high.
  always_comb begin
    w_state_next = r_state;
    w_ph_next    = r_ph;
    w_idx_next   = r_idx;
    w_sample     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_tick_next && enable) begin
          w_state_next = ST_LATCH;
          w_ph_next    = '0;
        end else begin
          w_state_next = ST_IDLE;
          w_ph_next    = '0;
        end
      end
      ST_LATCH: begin
        if (r_ph == LATCH_LAST) begin
          w_state_next = ST_LOW;
          w_ph_next    = '0;
          w_idx_next   = '0;
        end else begin
          w_ph_next = r_ph + PH_W'(1);
        end
      end
      ST_LOW: begin
        if (r_ph == HALF_LAST) begin
          w_state_next = ST_HIGH;
          w_ph_next    = '0;
          w_sample     = 1'b1;
        end else begin
          w_ph_next = r_ph + PH_W'(1);
        end
      end
      ST_HIGH: begin
        if (r_ph == HALF_LAST) begin
          w_ph_next = '0;
          if (r_idx == IDX_LAST) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_LOW;
            w_idx_next   = r_idx + IDX_W'(1);
          end
        end else begin
          w_ph_next = r_ph + PH_W'(1);
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
        w_ph_next    = '0;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_ph_next    = '0;
        w_idx_next   = '0;
      end
    endcase
  end

  // Per-bit capture: on the last LOW cycle, bit r_idx of every pad is loaded
  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    for (genvar i = 0; i < NUM_BITS; i++) begin : g_bit
      assign w_shift_next[p*NUM_BITS + i] =
        (w_sample && (r_idx == IDX_W'(i))) ? pad_data[p] : r_shift[p*NUM_BITS + i];
    end
  end

  // State, counters, capture register and registered waveform outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_ph      <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_latch   <= 1'b0;
      r_pulse   <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_buttons <= '0;
    end else begin
      r_state <= w_state_next;
      r_ph    <= w_ph_next;
      r_idx   <= w_idx_next;
      r_shift <= w_shift_next;
      r_latch <= (w_state_next == ST_LATCH);
      r_pulse <= (w_state_next == ST_HIGH);
      r_valid <= (w_state_next == ST_DONE);
      r_busy  <= (w_state_next != ST_IDLE);
      if (w_state_next == ST_DONE) begin
        r_buttons <= ~r_shift;
      end else begin
        r_buttons <= r_buttons;
      end
    end
  end

`ifdef PAD_PRESS_EDGE_EN
  logic [TOTAL-1:0] r_pressed;

  // Newly pressed buttons, shown only in the publish cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pressed <= '0;
    end else if (w_state_next == ST_DONE) begin
      r_pressed <= ~r_shift & ~r_buttons;
    end else begin
      r_pressed <= '0;
    end
  end

  assign buttons_pressed = r_pressed;
`endif

  assign latch         = r_latch;
  assign pulse         = r_pulse;
  assign buttons       = r_buttons;
  assign buttons_valid = r_valid;
  assign busy          = r_busy;

endmodule
